puf_ro_counter_cmp: RTL and testbench
=====================================

# puf_ro_counter_cmp

Measurement back end of the ring-oscillator PUF. Takes two (pre-divided) ring-oscillator outputs built from the PUF inverter cells and counts the rising edges of each over a programmable gate window in the system clock domain. At the end of the window it compares the two counts and produces one response bit plus the raw counts. A start/busy/done handshake lets the challenge sequencer run one comparison per request.

## Interface

- `CNT_BIT_SIZE`, 16: width of each edge counter and of `o_cnt_a` and `o_cnt_b`.
- `WIN_BIT_SIZE`, 12: width of the gate-window length input.

- `i_clk`  input  1  system clock; all logic is on the rising edge.
- `i_rst`  input  1  reset, synchronous and active-high.
- `i_start`  input  1  measurement request; sampled only in IDLE.
- `i_win_len`  input  WIN_BIT_SIZE  gate window length in clock cycles; captured when `i_start` is accepted; 0 means 2^WIN_BIT_SIZE.
- `i_ro_a`  input  1  ring-oscillator A output; asynchronous to `i_clk`.
- `i_ro_b`  input  1  ring-oscillator B output; asynchronous to `i_clk`.
- `o_busy`  output  1  high from the cycle after acceptance up to, but not including, the done cycle.
- `o_done`  output  1  single-cycle pulse; results are valid from this cycle.
- `o_resp`  output  1  response bit: 1 if and only if cnt_a > cnt_b.
- `o_tie`  output  1  set when cnt_a == cnt_b.
- `o_ovf`  output  1  set when either counter saturated during the window.
- `o_cnt_a`  output  CNT_BIT_SIZE  final edge count of A.
- `o_cnt_b`  output  CNT_BIT_SIZE  final edge count of B.

## Operation

- Each RO input passes through a 2-flop synchronizer and then a third register.
  - Rising edge = sync2 & ~sync3.
  - Input high and low phases must each last at least 2 `i_clk` periods; the divider upstream guarantees this.
- FSM states are IDLE, SETTLE, COUNT and DONE.
- IDLE
  - On `i_start`=1, go to SETTLE.
  - In the same transition: clear both counters and the ovf flag, and load the window counter with `i_win_len` (0 loads 2^WIN_BIT_SIZE).
- SETTLE
  - Lasts exactly 3 cycles to flush the synchronizer and edge-detect pipeline.
  - No counting in this state.
- COUNT
  - Lasts exactly N cycles (N = loaded window length).
  - Each cycle with a detected edge increments that RO's counter.
  - Both counters may increment in the same cycle.
  - Counters saturate at 2^CNT_BIT_SIZE−1; incrementing at the maximum holds the value and sets the ovf flag.
  - The window counter decrements once per cycle; on the last COUNT cycle go to DONE.
- Result registers are loaded on the clock edge that leaves COUNT:
  - `o_cnt_a` and `o_cnt_b` take the final counts.
  - `o_resp` = (cnt_a > cnt_b), unsigned compare.
  - `o_tie` = (cnt_a == cnt_b).
  - `o_ovf` = the ovf flag.
- On saturation the compare uses the saturated values; both saturated gives tie=1, resp=0.
- DONE
  - Lasts 1 cycle with `o_done`=1, then returns to IDLE.
  - `i_start` is ignored in DONE.
- `i_start` is ignored while busy, i.e. in SETTLE and COUNT; such a request is not queued.
- Result outputs hold until the next acceptance and are not cleared at start.

## Timing

- Reset, in any state:
  - Next state is IDLE.
  - All outputs are 0: `o_busy`, `o_done`, `o_resp`, `o_tie`, `o_ovf`, `o_cnt_a`, `o_cnt_b`.
  - Counters, window counter and synchronizer flops are cleared.
- Reset during SETTLE or COUNT aborts the measurement; no `o_done` is produced.
- With `i_start` accepted in cycle T:
  - `o_busy`=1 in cycles T+1 … T+3+N.
  - SETTLE occupies T+1 … T+3.
  - COUNT occupies T+4 … T+3+N.
  - `o_done`=1 and results are valid in cycle T+4+N; `o_busy`=0 in that cycle.
- Start-to-done latency is N+4 cycles.
- Earliest next acceptance is cycle T+5+N.
- An edge contributes to the count if its detect pulse falls in a COUNT cycle. Bench tolerance on the counts is ±1 per RO.

## Test plan

- Basic compare
  - Stimulus: A period 4 clk, B period 6 clk, `i_win_len`=120, start at T.
  - Required: `o_done` at T+124; cnt_a=30±1, cnt_b=20±1, resp=1, tie=0, ovf=0; `o_busy` high for exactly 123 cycles.
- Tie
  - Stimulus: A and B driven from the same period-8 clock-synchronous waveform, `i_win_len`=64.
  - Required: cnt_a == cnt_b == 8±1, tie=1, resp=0.
- Saturation
  - Stimulus: CNT_BIT_SIZE=4, A period 4, B period 8, `i_win_len`=200.
  - Required: cnt_a=15, cnt_b=15, ovf=1, tie=1, resp=0.
- Zero window
  - Stimulus: WIN_BIT_SIZE=4, `i_win_len`=0.
  - Required: window is 16 cycles, `o_done` at T+20.
- Start ignored while busy
  - Stimulus: pulse `i_start` during SETTLE, during COUNT and in the DONE cycle.
  - Required: exactly one `o_done`; a start at T+5+N is accepted.
- Reset mid-COUNT
  - Stimulus: assert `i_rst` for 1 cycle during COUNT.
  - Required: all outputs 0 the next cycle, no `o_done`; a subsequent start produces a correct result.

Source files
------------

// File: rtl/puf_ro_counter_cmp.sv
// puf_ro_counter_cmp
// Measurement back end of the ring-oscillator PUF. Counts rising edges of two
// asynchronous (pre-divided) RO outputs over a programmable gate window and
// compares the two counts to produce one response bit.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_start             measurement request (only looked at in IDLE)
//   i_win_len           gate window in clock cycles, 0 means 2^WIN_BIT_SIZE
//   i_ro_a, i_ro_b      ring-oscillator outputs, asynchronous to i_clk
//   o_busy              measurement in flight (SETTLE or COUNT)
//   o_done              one-cycle pulse, results valid from this cycle
//   o_resp, o_tie       cnt_a > cnt_b, cnt_a == cnt_b
//   o_ovf               a counter saturated during the window
//   o_cnt_a, o_cnt_b    final edge counts (held until the next acceptance)
//   o_dbg_state         current FSM state, for checkers and debug
//
// Handshake: a request is accepted in any cycle where the FSM is IDLE and
// i_start is high; o_busy then rises on the next cycle and stays high until
// o_done pulses for exactly one cycle. i_start outside IDLE is dropped, not
// queued, so the requester must wait for o_done before asking again.
module puf_ro_counter_cmp #(
  parameter int CNT_BIT_SIZE = 16,
  parameter int WIN_BIT_SIZE = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [WIN_BIT_SIZE-1:0] i_win_len,
  input  logic                    i_ro_a,
  input  logic                    i_ro_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_resp,
  output logic                    o_tie,
  output logic                    o_ovf,
  output logic [CNT_BIT_SIZE-1:0] o_cnt_a,
  output logic [CNT_BIT_SIZE-1:0] o_cnt_b,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_BIT_SIZE-1:0] CNT_ONE = 1;
  localparam logic [WIN_BIT_SIZE:0]   WIN_ONE = 1;

  state_t state, state_nxt;

  // [0],[1] form the synchronizer, [2] is the extra stage for edge detect.
  logic [2:0] sync_a, sync_b;
  logic       edge_a, edge_b;

  logic [1:0]              settle_cnt;
  // One bit wider than the input so a zero length can load 2^WIN_BIT_SIZE.
  logic [WIN_BIT_SIZE:0]   win_cnt;
  logic [WIN_BIT_SIZE:0]   win_load;
  logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_b;
  logic [CNT_BIT_SIZE-1:0] cnt_a_nxt, cnt_b_nxt;
  logic                    ovf_flag, ovf_nxt;
  logic                    accept, count_last;

  assign edge_a = sync_a[1] & ~sync_a[2];
  assign edge_b = sync_b[1] & ~sync_b[2];

  assign accept     = (state == ST_IDLE) && i_start;
  assign count_last = (state == ST_COUNT) && (win_cnt == WIN_ONE);
  assign win_load   = (i_win_len == '0) ? {1'b1, {WIN_BIT_SIZE{1'b0}}}
                                        : {1'b0, i_win_len};

  // Saturating increments: at all-ones the count holds and ovf is raised.
  always_comb begin
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    ovf_nxt   = ovf_flag;
    if (edge_a) begin
      if (&cnt_a) ovf_nxt = 1'b1;
      else        cnt_a_nxt = cnt_a + CNT_ONE;
    end
    if (edge_b) begin
      if (&cnt_b) ovf_nxt = 1'b1;
      else        cnt_b_nxt = cnt_b + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 2'd2) state_nxt = ST_COUNT;
      ST_COUNT:  if (win_cnt == WIN_ONE) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[1:0], i_ro_a};
      sync_b <= {sync_b[1:0], i_ro_b};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      ovf_flag   <= 1'b0;
      o_cnt_a    <= '0;
      o_cnt_b    <= '0;
      o_resp     <= 1'b0;
      o_tie      <= 1'b0;
      o_ovf      <= 1'b0;
    end else begin
      if (accept) begin
        settle_cnt <= '0;
        win_cnt    <= win_load;
        cnt_a      <= '0;
        cnt_b      <= '0;
        ovf_flag   <= 1'b0;
      end
      if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      if (state == ST_COUNT) begin
        cnt_a    <= cnt_a_nxt;
        cnt_b    <= cnt_b_nxt;
        ovf_flag <= ovf_nxt;
        win_cnt  <= win_cnt - WIN_ONE;
      end
      // The last COUNT cycle's edges are folded in via the *_nxt values.
      if (count_last) begin
        o_cnt_a <= cnt_a_nxt;
        o_cnt_b <= cnt_b_nxt;
        o_resp  <= cnt_a_nxt > cnt_b_nxt;
        o_tie   <= cnt_a_nxt == cnt_b_nxt;
        o_ovf   <= ovf_nxt;
      end
    end
  end

  assign o_busy      = (state == ST_SETTLE) || (state == ST_COUNT);
  assign o_done      = (state == ST_DONE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_puf_ro_counter_cmp.sv
module tb_puf_ro_counter_cmp;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic ro_a, ro_b;
  logic start_v [NI];
  logic [11:0] win0;
  logic [7:0]  win1;
  logic [3:0]  win2;
  logic busy_o [NI], done_o [NI], resp_o [NI], tie_o [NI], ovf_o [NI];
  logic [15:0] cnt_a0, cnt_b0;
  logic [3:0]  cnt_a1, cnt_b1;
  logic [7:0]  cnt_a2, cnt_b2;
  logic [1:0]  st0, st1, st2;
  int ca_o [NI];
  int cb_o [NI];

  assign ca_o[0] = int'(cnt_a0);
  assign cb_o[0] = int'(cnt_b0);
  assign ca_o[1] = int'(cnt_a1);
  assign cb_o[1] = int'(cnt_b1);
  assign ca_o[2] = int'(cnt_a2);
  assign cb_o[2] = int'(cnt_b2);

  // Instance 0: default sizes. Instance 1: 4-bit counters (saturation).
  // Instance 2: 4-bit window (zero-length window = 16 cycles).
  puf_ro_counter_cmp #(.CNT_BIT_SIZE(16), .WIN_BIT_SIZE(12)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_win_len(win0),
    .i_ro_a(ro_a), .i_ro_b(ro_b), .o_busy(busy_o[0]), .o_done(done_o[0]),
    .o_resp(resp_o[0]), .o_tie(tie_o[0]), .o_ovf(ovf_o[0]),
    .o_cnt_a(cnt_a0), .o_cnt_b(cnt_b0), .o_dbg_state(st0));

  puf_ro_counter_cmp #(.CNT_BIT_SIZE(4), .WIN_BIT_SIZE(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_win_len(win1),
    .i_ro_a(ro_a), .i_ro_b(ro_b), .o_busy(busy_o[1]), .o_done(done_o[1]),
    .o_resp(resp_o[1]), .o_tie(tie_o[1]), .o_ovf(ovf_o[1]),
    .o_cnt_a(cnt_a1), .o_cnt_b(cnt_b1), .o_dbg_state(st1));

  puf_ro_counter_cmp #(.CNT_BIT_SIZE(8), .WIN_BIT_SIZE(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_win_len(win2),
    .i_ro_a(ro_a), .i_ro_b(ro_b), .o_busy(busy_o[2]), .o_done(done_o[2]),
    .o_resp(resp_o[2]), .o_tie(tie_o[2]), .o_ovf(ovf_o[2]),
    .o_cnt_a(cnt_a2), .o_cnt_b(cnt_b2), .o_dbg_state(st2));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int done_seen [NI];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] cyc=%0d got=%0d want=%0d", name, idx, cyc, act, exp);
  endtask

  // ---------------- RO stimulus ----------------
  // half_* > 0: fixed half period; 0: each phase random 2..6 cycles.
  int half_a = 2;
  int half_b = 3;
  bit same_b = 1'b0;

  initial begin
    int ta, tb;
    ro_a = 1'b0;
    ro_b = 1'b0;
    ta = 1;
    tb = 1;
    forever begin
      @(posedge clk); #1;
      ta--;
      if (ta <= 0) begin
        ro_a = ~ro_a;
        ta = (half_a > 0) ? half_a : int'($urandom_range(2, 6));
      end
      tb--;
      if (tb <= 0) begin
        ro_b = ~ro_b;
        tb = (half_b > 0) ? half_b : int'($urandom_range(2, 6));
      end
      if (same_b) ro_b = ro_a;
    end
  end

  // ---------------- behavioural model + compare ----------------
  // Transaction-level view: a request accepted in cycle T with window N is
  // busy in T+1..T+3+N, done in T+4+N, and counts RO rises that occur in
  // cycles T+2..T+1+N (a rise needs two cycles to reach the edge detector).
  int cmax  [NI] = '{65535, 15, 255};
  int wfull [NI] = '{4096, 256, 16};
  bit active [NI];
  int t_acc [NI], n_win [NI], acc_a [NI], acc_b [NI];
  int e_ca [NI], e_cb [NI];
  bit e_resp [NI], e_tie [NI], e_ovf [NI];

  function automatic int win_of(input int i);
    case (i)
      0:       return int'(win0);
      1:       return int'(win1);
      default: return int'(win2);
    endcase
  endfunction

  initial begin
    bit prev_a, prev_b, ra, rb, eb, ed;
    int fa, fb;
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < NI; i++) begin
      active[i] = 1'b0; done_seen[i] = 0;
      e_ca[i] = 0; e_cb[i] = 0; e_resp[i] = 0; e_tie[i] = 0; e_ovf[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      ra = ro_a && !prev_a;
      rb = ro_b && !prev_b;
      prev_a = ro_a;
      prev_b = ro_b;
      for (int i = 0; i < NI; i++) begin
        if (done_o[i] === 1'b1) done_seen[i]++;
        if (chk_en) begin
          eb = active[i] && cyc >= t_acc[i] + 1 && cyc <= t_acc[i] + 3 + n_win[i];
          ed = active[i] && cyc == t_acc[i] + 4 + n_win[i];
          check("busy",  i, int'(busy_o[i]), int'(eb));
          check("done",  i, int'(done_o[i]), int'(ed));
          check("cnt_a", i, ca_o[i], e_ca[i]);
          check("cnt_b", i, cb_o[i], e_cb[i]);
          check("resp",  i, int'(resp_o[i]), int'(e_resp[i]));
          check("tie",   i, int'(tie_o[i]), int'(e_tie[i]));
          check("ovf",   i, int'(ovf_o[i]), int'(e_ovf[i]));
        end
        if (rst) begin
          active[i] = 1'b0;
          e_ca[i] = 0; e_cb[i] = 0; e_resp[i] = 0; e_tie[i] = 0; e_ovf[i] = 0;
        end else if (active[i]) begin
          if (cyc >= t_acc[i] + 2 && cyc <= t_acc[i] + 1 + n_win[i]) begin
            acc_a[i] += int'(ra);
            acc_b[i] += int'(rb);
          end
          if (cyc == t_acc[i] + 3 + n_win[i]) begin
            fa = (acc_a[i] > cmax[i]) ? cmax[i] : acc_a[i];
            fb = (acc_b[i] > cmax[i]) ? cmax[i] : acc_b[i];
            e_ca[i]   = fa;
            e_cb[i]   = fb;
            e_resp[i] = fa > fb;
            e_tie[i]  = fa == fb;
            e_ovf[i]  = (acc_a[i] > cmax[i]) || (acc_b[i] > cmax[i]);
          end
          if (cyc == t_acc[i] + 4 + n_win[i]) active[i] = 1'b0;
        end else if (start_v[i]) begin
          active[i] = 1'b1;
          t_acc[i]  = cyc;
          n_win[i]  = (win_of(i) == 0) ? wfull[i] : win_of(i);
          acc_a[i]  = 0;
          acc_b[i]  = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int idx, input int len);
    case (idx)
      0:       win0 = 12'(len);
      1:       win1 = 8'(len);
      default: win2 = 4'(len);
    endcase
  endtask

  task automatic pulse(input int idx);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
  endtask

  // Counts negedges from the current cycle until done (inclusive).
  task automatic wait_done(input int idx, output int k, output int bn);
    k = 1;
    bn = 0;
    forever begin
      @(negedge clk);
      if (busy_o[idx]) bn++;
      if (done_o[idx]) break;
      k++;
      if (k > 6000) begin
        check("done_timeout", idx, k, -1);
        break;
      end
    end
  endtask

  // Start in cycle T; returns at the done negedge with lat = done - T.
  task automatic run(input int idx, input int len, output int lat, output int bn);
    int k;
    @(posedge clk); #1;
    set_win(idx, len);
    pulse(idx);
    wait_done(idx, k, bn);
    lat = k;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, bn, dc0, n, idx, len;
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    win0 = '0; win1 = '0; win2 = '0;
    rst = 1'b1;
    step(4);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 0, int'(busy_o[0]), 0);
    check("rst_cnt_a", 0, ca_o[0], 0);

    // Basic compare: A period 4, B period 6, window 120.
    step(5);
    run(0, 120, lat, bn);
    check("basic_lat", 0, lat, 124);
    check("basic_busy", 0, bn, 123);
    check("basic_cnt_a", 0, ca_o[0], 30);
    check("basic_cnt_b", 0, cb_o[0], 20);
    check("basic_resp", 0, int'(resp_o[0]), 1);
    check("basic_tie", 0, int'(tie_o[0]), 0);
    check("basic_ovf", 0, int'(ovf_o[0]), 0);

    // Tie: identical period-8 waveforms, window 64.
    half_a = 4; same_b = 1'b1;
    step(12);
    run(0, 64, lat, bn);
    check("tie_cnt_a", 0, ca_o[0], 8);
    check("tie_cnt_b", 0, cb_o[0], 8);
    check("tie_tie", 0, int'(tie_o[0]), 1);
    check("tie_resp", 0, int'(resp_o[0]), 0);

    // Saturation on 4-bit counters: A period 4, B period 8, window 200.
    same_b = 1'b0; half_a = 2; half_b = 4;
    step(12);
    run(1, 200, lat, bn);
    check("sat_lat", 1, lat, 204);
    check("sat_cnt_a", 1, ca_o[1], 15);
    check("sat_cnt_b", 1, cb_o[1], 15);
    check("sat_ovf", 1, int'(ovf_o[1]), 1);
    check("sat_tie", 1, int'(tie_o[1]), 1);
    check("sat_resp", 1, int'(resp_o[1]), 0);

    // Zero window and minimum window.
    run(2, 0, lat, bn);
    check("zero_lat_w4", 2, lat, 20);
    check("zero_busy_w4", 2, bn, 19);
    run(1, 0, lat, bn);
    check("zero_lat_w8", 1, lat, 260);
    run(0, 1, lat, bn);
    check("min_lat", 0, lat, 5);

    // Start ignored in SETTLE, COUNT and DONE; accepted at T+5+N (N=20).
    half_a = 2; half_b = 3;
    step(10);
    set_win(0, 20);
    dc0 = done_seen[0];
    pulse(0);     // T
    step(1);
    pulse(0);     // T+2, SETTLE
    step(7);
    pulse(0);     // T+10, COUNT
    step(13);
    pulse(0);     // T+24, DONE
    check("one_done", 0, done_seen[0] - dc0, 1);
    pulse(0);     // T+25, accepted
    wait_done(0, lat, bn);
    check("restart_lat", 0, lat, 24);
    check("two_done", 0, done_seen[0] - dc0, 2);

    // Reset for one cycle in the middle of COUNT.
    step(1);
    set_win(0, 50);
    pulse(0);     // T
    step(9);      // T+10
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 0, int'(busy_o[0]), 0);
    check("mid_rst_done", 0, int'(done_o[0]), 0);
    check("mid_rst_cnt_a", 0, ca_o[0], 0);
    check("mid_rst_cnt_b", 0, cb_o[0], 0);
    check("mid_rst_resp", 0, int'(resp_o[0]), 0);
    dc0 = done_seen[0];
    repeat (70) @(negedge clk);
    check("mid_rst_no_done", 0, done_seen[0] - dc0, 0);
    run(0, 40, lat, bn);
    check("post_rst_lat", 0, lat, 44);

    // Randomized measurements with jittered RO phases.
    half_a = 0; half_b = 0;
    for (int it = 0; it < 14; it++) begin
      idx = int'($urandom_range(0, 2));
      case (idx)
        0:       len = int'($urandom_range(1, 300));
        1:       len = int'($urandom_range(0, 255));
        default: len = int'($urandom_range(0, 15));
      endcase
      step(int'($urandom_range(0, 5)));
      run(idx, len, lat, bn);
      n = (len == 0) ? wfull[idx] : len;
      check("rand_lat", idx, lat, n + 4);
      check("rand_busy", idx, bn, n + 3);
    end

    step(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
